alu_issue_stage: RTL and testbench

//  Registered issue stage directly upstream of the 32-bit ALU (array of 1-bit ALU slices).

---
 rtl/alu_issue_stage.sv | 178 +++++++++++++++++
 tb/tb_alu_issue_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//
// Registered issue stage in front of the 32-bit ALU (an array of 1-bit slices).
// Operands are captured together with the slice controls decoded from
// ALUOp/funct. Those controls are the mux select, the B-invert and the carry-in.
// Everything is held stable for the ALU behind a valid/ready handshake.
//
// Build option:
//   SKID_BUF_EN defined   : two-entry skid buffer (main + skid register).
//                           in_ready is registered ("skid entry empty").
//   SKID_BUF_EN undefined : single register, in_ready = !out_valid | out_ready.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   flush                 synchronous clear of all held entries
//   in_valid / in_ready   upstream handshake
//   in_a, in_b            operands (WIDTH bits)
//   in_aluop, in_funct    operation encoding (2-bit ALUOp, 6-bit R-type funct)
//   out_valid / out_ready ALU-side handshake
//   out_a, out_b          registered operands
//   out_sel               slice mux select: 0 AND, 1 OR, 2 ADD, 3 LESS
//   out_inv, out_cin      B invert / carry into slice 0 (always equal)
//   out_illegal           unsupported op, decoded as a plain ADD
// -----------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_aluop,
    input  logic [5:0]       in_funct,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [1:0]       out_sel,
    output logic             out_inv,
    output logic             out_cin,
    output logic             out_illegal
);

    localparam logic [1:0] SEL_AND  = 2'd0;
    localparam logic [1:0] SEL_OR   = 2'd1;
    localparam logic [1:0] SEL_ADD  = 2'd2;
    localparam logic [1:0] SEL_LESS = 2'd3;

    // Returns {sel, inv, illegal}. Any unsupported op falls back to ADD and is flagged.
    function automatic logic [3:0] decode(input logic [1:0] aluop, input logic [5:0] funct);
        logic [3:0] d;
        d = {SEL_ADD, 1'b0, 1'b1};
        case (aluop)
            2'b00: d = {SEL_ADD, 1'b0, 1'b0};
            2'b01: d = {SEL_ADD, 1'b1, 1'b0};
            2'b10: begin
                case (funct)
                    6'b100000: d = {SEL_ADD,  1'b0, 1'b0};
                    6'b100010: d = {SEL_ADD,  1'b1, 1'b0};
                    6'b100100: d = {SEL_AND,  1'b0, 1'b0};
                    6'b100101: d = {SEL_OR,   1'b0, 1'b0};
                    // slt subtracts (inv + cin) and routes the sign to slice 0 via LESS
                    6'b101010: d = {SEL_LESS, 1'b1, 1'b0};
                    default:   d = {SEL_ADD,  1'b0, 1'b1};
                endcase
            end
            default: d = {SEL_ADD, 1'b0, 1'b1};
        endcase
        return d;
    endfunction

    logic [1:0] dec_sel;
    logic       dec_inv;
    logic       dec_ill;
    logic       in_fire;
    logic       out_fire;

    assign {dec_sel, dec_inv, dec_ill} = decode(in_aluop, in_funct);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // The carry into slice 0 completes the two's-complement negate of B.
    assign out_cin = out_inv;

`ifdef SKID_BUF_EN
    logic             skid_vld;
    logic [WIDTH-1:0] skid_a;
    logic [WIDTH-1:0] skid_b;
    logic [1:0]       skid_sel;
    logic             skid_inv;
    logic             skid_ill;

    // Registered ready: the skid slot can always absorb one more entry, so
    // out_ready never needs to reach upstream combinationally.
    assign in_ready = !skid_vld;

    // ---- issue register stage (main + skid) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_a       <= '0;
            out_b       <= '0;
            out_sel     <= SEL_ADD;
            out_inv     <= 1'b0;
            out_illegal <= 1'b0;
            skid_vld    <= 1'b0;
            skid_a      <= '0;
            skid_b      <= '0;
            skid_sel    <= SEL_ADD;
            skid_inv    <= 1'b0;
            skid_ill    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            skid_vld  <= 1'b0;
        end else if (out_fire || !out_valid) begin
            // Main frees up this edge: the older skid entry goes first. While the
            // skid is full in_ready is low, so no input can arrive at the same time.
            if (skid_vld) begin
                out_valid   <= 1'b1;
                out_a       <= skid_a;
                out_b       <= skid_b;
                out_sel     <= skid_sel;
                out_inv     <= skid_inv;
                out_illegal <= skid_ill;
                skid_vld    <= 1'b0;
            end else if (in_fire) begin
                out_valid   <= 1'b1;
                out_a       <= in_a;
                out_b       <= in_b;
                out_sel     <= dec_sel;
                out_inv     <= dec_inv;
                out_illegal <= dec_ill;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_fire) begin
            // Main is stalled: park the new entry in the skid slot.
            skid_vld <= 1'b1;
            skid_a   <= in_a;
            skid_b   <= in_b;
            skid_sel <= dec_sel;
            skid_inv <= dec_inv;
            skid_ill <= dec_ill;
        end
    end
`else
    // Ready depends on out_ready, not on in_valid.
    assign in_ready = !out_valid || out_ready;

    // ---- issue register stage (single entry) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_a       <= '0;
            out_b       <= '0;
            out_sel     <= SEL_ADD;
            out_inv     <= 1'b0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_fire) begin
            out_valid   <= 1'b1;
            out_a       <= in_a;
            out_b       <= in_b;
            out_sel     <= dec_sel;
            out_inv     <= dec_inv;
            out_illegal <= dec_ill;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [1:0]  in_aluop;
    logic [5:0]  in_funct;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [1:0]  out_sel;
    logic        out_inv;
    logic        out_cin;
    logic        out_illegal;

    always #5 clk = ~clk;

    alu_issue_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_aluop(in_aluop), .in_funct(in_funct),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_sel(out_sel),
        .out_inv(out_inv), .out_cin(out_cin), .out_illegal(out_illegal)
    );

`ifdef SKID_BUF_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  sel;
        logic        inv;
        logic        ill;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic last_in_hs;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: what the ALU should do for each operation, by name.
    function automatic ent_t expect_entry(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] aluop, input logic [5:0] funct);
        ent_t e;
        e.a = a; e.b = b; e.sel = 2'd2; e.inv = 1'b0; e.ill = 1'b0;   // plain add
        if (aluop == 2'b01) e.inv = 1'b1;                               // subtract
        else if (aluop == 2'b11) e.ill = 1'b1;                          // reserved
        else if (aluop == 2'b10) begin
            if (funct == 6'h20) begin end                               // add
            else if (funct == 6'h22) e.inv = 1'b1;                      // sub
            else if (funct == 6'h24) e.sel = 2'd0;                      // and
            else if (funct == 6'h25) e.sel = 2'd1;                      // or
            else if (funct == 6'h2A) begin e.sel = 2'd3; e.inv = 1'b1; end  // slt
            else e.ill = 1'b1;
        end
        return e;
    endfunction

    // One clock: check outputs against the model, then advance the model.
    task automatic step();
        logic exp_ready, in_hs, out_hs;
        @(negedge clk);
        if (CAP == 2) exp_ready = (q.size() < 2);
        else          exp_ready = (q.size() == 0) || out_ready;
        check("in_ready", in_ready, exp_ready);
        check("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("out_a", out_a, q[0].a);
            check("out_b", out_b, q[0].b);
            check("out_sel", out_sel, q[0].sel);
            check("out_inv", out_inv, q[0].inv);
            check("out_cin", out_cin, q[0].inv);
            check("out_illegal", out_illegal, q[0].ill);
        end
        in_hs  = in_valid && exp_ready;
        out_hs = (q.size() != 0) && out_ready;
        last_in_hs = in_hs && !flush;
        @(posedge clk);
        if (flush) q.delete();
        else begin
            if (out_hs) void'(q.pop_front());
            if (in_hs) q.push_back(expect_entry(in_a, in_b, in_aluop, in_funct));
        end
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_a"}, out_a, 32'h0);
        check({tag, "_b"}, out_b, 32'h0);
        check({tag, "_sel"}, out_sel, 2'd2);
        check({tag, "_inv"}, out_inv, 1'b0);
        check({tag, "_cin"}, out_cin, 1'b0);
        check({tag, "_illegal"}, out_illegal, 1'b0);
        check({tag, "_ready"}, in_ready, 1'b1);
    endtask

    task automatic send(input logic [1:0] aluop, input logic [5:0] funct,
                        input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1; in_aluop = aluop; in_funct = funct; in_a = a; in_b = b;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        repeat (3) step();
    endtask

    // Hold out_ready low with a continuous input stream; count accepted entries.
    task automatic fill_stalled(output int accepted);
        logic [31:0] data [4];
        int idx;
        data[0] = 32'h0000_0005; data[1] = 32'hFFFF_FFFF;
        data[2] = 32'h1234_5678; data[3] = 32'hA5A5_A5A5;
        idx = 0;
        out_ready = 1'b0; in_aluop = 2'b00; in_funct = 6'h00; in_b = 32'h1;
        repeat (3) begin
            in_valid = 1'b1; in_a = data[idx];
            step();
            if (last_in_hs) idx++;
        end
        in_valid = 1'b0;
        accepted = idx;
    endtask

    logic [5:0] legal_funct [5];

    initial begin
        int acc;
        legal_funct[0] = 6'h20; legal_funct[1] = 6'h22; legal_funct[2] = 6'h24;
        legal_funct[3] = 6'h25; legal_funct[4] = 6'h2A;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_aluop = '0; in_funct = '0; last_in_hs = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;

        // R-type stream, back to back
        for (int i = 0; i < 5; i++)
            send(2'b10, legal_funct[i], $urandom, $urandom);
        drain();

        // Unsupported funct and reserved ALUOp
        send(2'b10, 6'h27, 32'h11, 32'h22);
        send(2'b11, 6'h20, 32'h33, 32'h44);
        drain();

        // Subtract 7 - 3
        send(2'b01, 6'h00, 32'd7, 32'd3);
        drain();

        // Stall, then release
        fill_stalled(acc);
        check("stall_accepts", acc, CAP);
        drain();

        // Flush with an input offered while the stage is full
        fill_stalled(acc);
        flush = 1'b1; in_valid = 1'b1; in_a = 32'hDEAD_BEEF; in_aluop = 2'b00;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("flush_out_valid", out_valid, 1'b0);
        #1;
        drain();

        // Randomized traffic with a mid-stream asynchronous reset
        last_in_hs = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!in_valid || last_in_hs || flush) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_a     = $urandom;
                in_b     = $urandom;
                in_aluop = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 3) != 0) in_funct = legal_funct[$urandom_range(0, 4)];
                else                           in_funct = 6'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            if (cyc == 300) begin
                flush = 1'b0;
                @(posedge clk);
                #2 rst = 1'b1;
                #1 check_reset_vals("async_rst");
                q.delete();
                @(posedge clk);
                #1 rst = 1'b0;
                last_in_hs = 1'b1;
            end else begin
                step();
            end
        end
        flush = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
